mem_credit_arbiter: RTL and testbench
=====================================

Name: mem_credit_arbiter

Overview:
- Shares the memory controller request channel between NPORT pipeline ports using round-robin arbitration gated by a credit counter.
- Each granted request consumes one memory network credit; the controller returns credits with a pulse.
- Provides a drain mode that blocks new grants until all credits are back, so the memory network can be quiesced before reconfiguration or debug DMA.

Parameters:
- NPORT, 4, number of requesting pipeline ports (2..8).
- MAXCREDIT, 64, credits available after reset.
- CREDITW, 7, credit counter width, log2x(MAXCREDIT)+1, so the counter holds 0..MAXCREDIT.
- PORTW, 2, port index width, log2x(NPORT).

Ports:
- gclk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NPORT  per-port request; held high until granted.
- gnt  out  NPORT  one-hot grant, registered, single-cycle pulse.
- mem_valid  out  1  request issued to controller this cycle (equals |gnt).
- mem_port  out  PORTW  index of the granted port, valid when mem_valid.
- credit_ret  in  1  one credit returned this cycle.
- drain_req  in  1  level; enter drain mode.
- drain_done  out  1  high while drained (no outstanding credits).
- credit_cnt  out  CREDITW  current available credits.
- credit_err  out  1  sticky; set when a credit return would exceed MAXCREDIT.

Behaviour:
- Reset (async, rst_n=0):
  - gnt=0, mem_valid=0, mem_port=0, drain_done=0, credit_err=0.
  - credit_cnt=MAXCREDIT, round-robin pointer last=NPORT-1, state=RUN.
- Arbitration (state RUN, evaluated each cycle):
  - eligible when credit_cnt>0 and req!=0.
  - Winner is the first set req bit scanning from last+1 upward with wrap to 0.
  - On the next edge: gnt[winner]=1, mem_valid=1, mem_port=winner, last=winner.
  - Grant is registered: one-cycle latency from req to gnt.
  - A port seeing gnt must drop or re-present req in the same cycle. The arbiter masks the port granted in the previous cycle for one cycle, so a stale req never produces a back-to-back double grant from one request.
  - At most one grant per cycle.
- Credit arithmetic, per cycle:
  - next = credit_cnt - grant_issued + credit_ret.
  - Grant and return in the same cycle: count unchanged.
  - credit_cnt=0: no grant, even with a same-cycle credit_ret. The return is visible next cycle.
  - Return with credit_cnt=MAXCREDIT and no grant that cycle: count saturates at MAXCREDIT and credit_err sets; it clears only on reset.
- State machine:
  - RUN: normal arbitration. drain_req=1 moves to DRAIN next cycle. A grant decided in the same cycle drain_req rises still issues.
  - DRAIN: no new grants; credit returns continue. When credit_cnt==MAXCREDIT, go to DONE.
  - DONE: drain_done=1, no grants. drain_req=0 moves to RUN next cycle, and drain_done falls that same edge.
  - DRAIN with drain_req=0 before completion: return to RUN.
  - Reset mid-operation: all outstanding credits are forgotten and the counter reloads to MAXCREDIT. The controller must be reset together with this block.
- credit_cnt is the registered counter value, never the combinational next value.

Test Plan:
- Reset then ports 0 and 2 hold req:
  - gnt alternates 0001, 0100, 0001, …
  - mem_port alternates 0, 2, …
  - credit_cnt decrements 64, 63, 62, … with no credit_ret.
- All 4 ports request continuously, no returns:
  - exactly 64 grants in order 0, 1, 2, 3, 0, …
  - then credit_cnt=0 and gnt stays 0.
  - one credit_ret pulse produces exactly one further grant, two cycles later.
- credit_cnt=10, grant and credit_ret in the same cycle → credit_cnt stays 10.
- 5 credits outstanding, drain_req=1:
  - no grants despite req.
  - after 5 credit_ret pulses, credit_cnt=64 and drain_done=1 the following cycle.
  - drain_req=0 → arbitration resumes from last+1.
- Idle with credit_cnt=64, credit_ret=1 → credit_cnt stays 64 and credit_err=1, still set 100 cycles later.
- Assert rst_n=0 mid-stream with credit_cnt=30 → immediately gnt=0 and credit_cnt=64; after release, the first grant goes to port 0.

Source files
------------

// File: rtl/mem_credit_arbiter.sv
// Round-robin arbiter sharing the memory request channel between NPORT ports, gated by network credits.
// Latency: one cycle from req to the registered one-hot gnt; credit_cnt is always the registered count.
// Backpressure: no grant while credits are exhausted or while draining; the port granted last cycle is masked for one cycle.
module mem_credit_arbiter #(
   parameter int NPORT     = 4,
   parameter int MAXCREDIT = 64,
   parameter int CREDITW   = 7,
   parameter int PORTW     = 2
) (
   input  logic               gclk,
   input  logic               rst_n,
   input  logic [NPORT-1:0]   req,
   output logic [NPORT-1:0]   gnt,
   output logic               mem_valid,
   output logic [PORTW-1:0]   mem_port,
   input  logic               credit_ret,
   input  logic               drain_req,
   output logic               drain_done,
   output logic [CREDITW-1:0] credit_cnt,
   output logic               credit_err
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [CREDITW-1:0] CREDIT_FULL = CREDITW'(MAXCREDIT);
   localparam logic [CREDITW-1:0] CREDIT_ONE  = CREDITW'(1);
   localparam logic [NPORT-1:0]   PORT_ONE    = NPORT'(1);

   state_t               state;
   logic [PORTW-1:0]     last;
   logic [NPORT-1:0]     req_live;
   logic                 eligible;
   logic                 found;
   logic [PORTW-1:0]     winner;
   logic [PORTW-1:0]     scan_idx;
   logic                 issue;
   logic [CREDITW-1:0]   credit_nxt;
   logic                 overflow;

   // A port granted last cycle is still showing the request it was just served for
   assign req_live = req & ~gnt;

   // Grants only happen in RUN, with at least one credit and a live request
   assign eligible = (state == RUN) && (credit_cnt != '0) && (req_live != '0);
   assign issue    = eligible && found;

   // Rotating-priority scan: first live request strictly above the last winner, wrapping to port 0
   always_comb begin
      found    = 1'b0;
      winner   = '0;
      scan_idx = '0;
      for (int k = 1; k <= NPORT; k++) begin
         scan_idx = PORTW'((int'(last) + k) % NPORT);
         if (!found && req_live[scan_idx]) begin
            found  = 1'b1;
            winner = scan_idx;
         end
      end
   end

   // Next credit count: a grant and a return in the same cycle cancel out; a return into a full pool is an error
   always_comb begin
      credit_nxt = credit_cnt;
      overflow   = 1'b0;
      if (issue && !credit_ret) begin
         credit_nxt = credit_cnt - CREDIT_ONE;
      end else if (!issue && credit_ret) begin
         if (credit_cnt == CREDIT_FULL) begin
            overflow = 1'b1;
         end else begin
            credit_nxt = credit_cnt + CREDIT_ONE;
         end
      end
   end

   // Registered grant outputs and round-robin pointer
   always_ff @(posedge gclk or negedge rst_n) begin
      if (!rst_n) begin
         gnt       <= '0;
         mem_valid <= 1'b0;
         mem_port  <= '0;
         last      <= PORTW'(NPORT - 1);
      end else begin
         mem_valid <= issue;
         gnt       <= issue ? (PORT_ONE << winner) : '0;
         if (issue) begin
            mem_port <= winner;
            last     <= winner;
         end
      end
   end

   // Credit pool and sticky overflow flag; reset forgets anything outstanding
   always_ff @(posedge gclk or negedge rst_n) begin
      if (!rst_n) begin
         credit_cnt <= CREDIT_FULL;
         credit_err <= 1'b0;
      end else begin
         credit_cnt <= credit_nxt;
         if (overflow) begin
            credit_err <= 1'b1;
         end
      end
   end

   // Drain sequencing: stop granting, wait for every credit to return, hold DONE until released
   always_ff @(posedge gclk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RUN;
         drain_done <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (drain_req) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (!drain_req) begin
                  state <= RUN;
               end else if (credit_cnt == CREDIT_FULL) begin
                  state      <= DONE;
                  drain_done <= 1'b1;
               end
            end
            DONE: begin
               if (!drain_req) begin
                  state      <= RUN;
                  drain_done <= 1'b0;
               end
            end
            default: begin
               state      <= RUN;
               drain_done <= 1'b0;
            end
         endcase
      end
   end

   // Structural invariants of the output interface
   a_valid_matches_gnt : assert property (@(posedge gclk) disable iff (!rst_n) mem_valid == (|gnt));
   a_gnt_onehot0       : assert property (@(posedge gclk) disable iff (!rst_n) $onehot0(gnt));
   a_credit_bounded    : assert property (@(posedge gclk) disable iff (!rst_n) credit_cnt <= CREDIT_FULL);

endmodule

// File: tb/tb_mem_credit_arbiter.sv
// Bench for mem_credit_arbiter: directed vector table, hand-built corner sequences, randomized run against a model.
// Inputs change 1ns after each rising edge; outputs are sampled 1ns after the edge that registers them.
// The model tracks credits, pointer and drain mode as plain integers.
module tb_mem_credit_arbiter;

   localparam int NPORT     = 4;
   localparam int MAXCREDIT = 64;
   localparam int CREDITW   = 7;
   localparam int PORTW     = 2;

   logic               gclk = 1'b0;
   logic               rst_n = 1'b1;
   logic [NPORT-1:0]   req = '0;
   logic               credit_ret = 1'b0;
   logic               drain_req = 1'b0;
   logic [NPORT-1:0]   gnt;
   logic               mem_valid;
   logic [PORTW-1:0]   mem_port;
   logic               drain_done;
   logic [CREDITW-1:0] credit_cnt;
   logic               credit_err;

   mem_credit_arbiter #(
      .NPORT(NPORT), .MAXCREDIT(MAXCREDIT), .CREDITW(CREDITW), .PORTW(PORTW)
   ) dut (
      .gclk(gclk), .rst_n(rst_n), .req(req), .gnt(gnt), .mem_valid(mem_valid),
      .mem_port(mem_port), .credit_ret(credit_ret), .drain_req(drain_req),
      .drain_done(drain_done), .credit_cnt(credit_cnt), .credit_err(credit_err)
   );

   always #5 gclk = ~gclk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int m_cnt;
   int m_last;
   int m_prev;
   int m_mode;   // 0 run, 1 draining, 2 drained
   int m_err;
   int m_win;

   typedef struct {
      logic [NPORT-1:0] r;
      logic             ret;
      logic             drn;
      logic [NPORT-1:0] egnt;
      int               ecnt;
      logic             edone;
   } vec_t;

   vec_t tbl [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt  = MAXCREDIT;
      m_last = NPORT - 1;
      m_prev = -1;
      m_mode = 0;
      m_err  = 0;
      m_win  = -1;
   endtask

   task automatic model_step(input logic [NPORT-1:0] r, input logic ret, input logic drn);
      int w;
      int nc;
      w = -1;
      if (m_mode == 0 && m_cnt > 0) begin
         for (int k = 1; k <= NPORT; k++) begin
            int p;
            p = (m_last + k) % NPORT;
            if (w < 0 && r[p] && p != m_prev) w = p;
         end
      end
      nc = m_cnt - ((w >= 0) ? 1 : 0) + (ret ? 1 : 0);
      if (nc > MAXCREDIT) begin
         nc    = MAXCREDIT;
         m_err = 1;
      end
      case (m_mode)
         0: if (drn) m_mode = 1;
         1: if (!drn) m_mode = 0; else if (m_cnt == MAXCREDIT) m_mode = 2;
         default: if (!drn) m_mode = 0;
      endcase
      m_cnt  = nc;
      m_prev = w;
      if (w >= 0) m_last = w;
      m_win  = w;
   endtask

   // One clock: drive inputs, let the edge happen, advance the model, settle
   task automatic cycle(input logic [NPORT-1:0] r, input logic ret, input logic drn);
      req        = r;
      credit_ret = ret;
      drain_req  = drn;
      @(posedge gclk);
      model_step(r, ret, drn);
      #1;
   endtask

   task automatic check_model(input string tag);
      logic [NPORT-1:0] eg;
      eg = '0;
      if (m_win >= 0) eg[m_win] = 1'b1;
      chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
      chk({tag, ".mem_valid"}, 32'(mem_valid), (m_win >= 0) ? 32'd1 : 32'd0);
      if (m_win >= 0) chk({tag, ".mem_port"}, 32'(mem_port), 32'(m_win));
      chk({tag, ".credit_cnt"}, 32'(credit_cnt), 32'(m_cnt));
      chk({tag, ".drain_done"}, 32'(drain_done), (m_mode == 2) ? 32'd1 : 32'd0);
      chk({tag, ".credit_err"}, 32'(credit_err), 32'(m_err));
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge
   task automatic do_reset();
      req        = '0;
      credit_ret = 1'b0;
      drain_req  = 1'b0;
      rst_n      = 1'b0;
      #1;
      chk("async_rst.gnt", 32'(gnt), 32'd0);
      chk("async_rst.mem_valid", 32'(mem_valid), 32'd0);
      chk("async_rst.credit_cnt", 32'(credit_cnt), 32'(MAXCREDIT));
      chk("async_rst.credit_err", 32'(credit_err), 32'd0);
      chk("async_rst.drain_done", 32'(drain_done), 32'd0);
      chk("async_rst.mem_port", 32'(mem_port), 32'd0);
      @(posedge gclk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      int               n;
      int               eidx;
      int               hold;
      logic             d;
      logic [NPORT-1:0] rr;
      logic             rt;

      // Directed vectors starting from reset: ports 0 and 2 alternate, then masking and drain corners
      tbl[0]  = '{4'b0101, 1'b0, 1'b0, 4'b0001, 63, 1'b0};
      tbl[1]  = '{4'b0101, 1'b0, 1'b0, 4'b0100, 62, 1'b0};
      tbl[2]  = '{4'b0101, 1'b0, 1'b0, 4'b0001, 61, 1'b0};
      tbl[3]  = '{4'b0101, 1'b0, 1'b0, 4'b0100, 60, 1'b0};
      tbl[4]  = '{4'b0101, 1'b1, 1'b0, 4'b0001, 60, 1'b0};
      tbl[5]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 61, 1'b0};
      tbl[6]  = '{4'b0010, 1'b0, 1'b0, 4'b0010, 60, 1'b0};
      tbl[7]  = '{4'b0010, 1'b0, 1'b0, 4'b0000, 60, 1'b0};
      tbl[8]  = '{4'b0010, 1'b0, 1'b0, 4'b0010, 59, 1'b0};
      tbl[9]  = '{4'b0000, 1'b0, 1'b1, 4'b0000, 59, 1'b0};
      tbl[10] = '{4'b1111, 1'b0, 1'b1, 4'b0000, 59, 1'b0};
      tbl[11] = '{4'b1111, 1'b0, 1'b0, 4'b0000, 59, 1'b0};
      tbl[12] = '{4'b1000, 1'b0, 1'b0, 4'b1000, 58, 1'b0};

      #1 rst_n = 1'b0;
      repeat (2) @(posedge gclk);
      #1;
      chk("reset.gnt", 32'(gnt), 32'd0);
      chk("reset.mem_valid", 32'(mem_valid), 32'd0);
      chk("reset.mem_port", 32'(mem_port), 32'd0);
      chk("reset.credit_cnt", 32'(credit_cnt), 32'(MAXCREDIT));
      chk("reset.drain_done", 32'(drain_done), 32'd0);
      chk("reset.credit_err", 32'(credit_err), 32'd0);
      rst_n = 1'b1;
      model_reset();

      for (int i = 0; i < 13; i++) begin
         cycle(tbl[i].r, tbl[i].ret, tbl[i].drn);
         chk($sformatf("vec%0d.gnt", i), 32'(gnt), 32'(tbl[i].egnt));
         chk($sformatf("vec%0d.mem_valid", i), 32'(mem_valid), 32'(|tbl[i].egnt));
         chk($sformatf("vec%0d.credit_cnt", i), 32'(credit_cnt), 32'(tbl[i].ecnt));
         chk($sformatf("vec%0d.drain_done", i), 32'(drain_done), 32'(tbl[i].edone));
         if (tbl[i].egnt != '0) begin
            eidx = 0;
            for (int b = 0; b < NPORT; b++) if (tbl[i].egnt[b]) eidx = b;
            chk($sformatf("vec%0d.mem_port", i), 32'(mem_port), 32'(eidx));
         end
      end

      // Exhaust the pool with every port requesting
      do_reset();
      n = 0;
      for (int i = 0; i < 80; i++) begin
         cycle(4'hF, 1'b0, 1'b0);
         check_model("exhaust");
         if (gnt != '0) begin
            chk("exhaust.order", 32'(mem_port), 32'(n % NPORT));
            n++;
         end
      end
      chk("exhaust.grant_total", 32'(n), 32'd64);
      chk("exhaust.credit_cnt", 32'(credit_cnt), 32'd0);
      chk("exhaust.gnt_idle", 32'(gnt), 32'd0);
      // A return while empty does not allow a same-cycle grant; it grants one cycle later
      cycle(4'hF, 1'b1, 1'b0);
      chk("ret0.gnt", 32'(gnt), 32'd0);
      chk("ret0.credit_cnt", 32'(credit_cnt), 32'd1);
      cycle(4'hF, 1'b0, 1'b0);
      chk("ret1.gnt", 32'(gnt), 32'b0001);
      chk("ret1.credit_cnt", 32'(credit_cnt), 32'd0);
      cycle(4'hF, 1'b0, 1'b0);
      chk("ret2.gnt", 32'(gnt), 32'd0);

      // Grant and return together at 10 credits
      for (int i = 0; i < 10; i++) cycle(4'h0, 1'b1, 1'b0);
      chk("ten.credit_cnt", 32'(credit_cnt), 32'd10);
      cycle(4'b0010, 1'b1, 1'b0);
      chk("ten_both.gnt", 32'(gnt), 32'b0010);
      chk("ten_both.credit_cnt", 32'(credit_cnt), 32'd10);

      // Drain with five credits outstanding
      for (int i = 0; i < 49; i++) cycle(4'h0, 1'b1, 1'b0);
      chk("pre_drain.credit_cnt", 32'(credit_cnt), 32'd59);
      cycle(4'h0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cycle(4'hF, 1'b0, 1'b1);
         chk("drain_block.gnt", 32'(gnt), 32'd0);
      end
      for (int i = 0; i < 5; i++) begin
         cycle(4'hF, 1'b1, 1'b1);
         check_model("drain_ret");
      end
      chk("drain_full.credit_cnt", 32'(credit_cnt), 32'd64);
      chk("drain_full.drain_done", 32'(drain_done), 32'd0);
      cycle(4'hF, 1'b0, 1'b1);
      chk("drained.drain_done", 32'(drain_done), 32'd1);
      cycle(4'hF, 1'b0, 1'b1);
      chk("drained_hold.gnt", 32'(gnt), 32'd0);
      chk("drained_hold.drain_done", 32'(drain_done), 32'd1);
      cycle(4'hF, 1'b0, 1'b0);
      chk("undrain.drain_done", 32'(drain_done), 32'd0);
      chk("undrain.gnt", 32'(gnt), 32'd0);
      cycle(4'hF, 1'b0, 1'b0);
      chk("resume.gnt", 32'(gnt), 32'b0100);
      chk("resume.credit_cnt", 32'(credit_cnt), 32'd63);
      // Grant decided in the cycle drain_req rises still issues; early drain release returns to RUN
      cycle(4'hF, 1'b0, 1'b1);
      chk("drain_edge.gnt", 32'(gnt), 32'b1000);
      cycle(4'hF, 1'b0, 1'b0);
      chk("drain_abort.gnt", 32'(gnt), 32'd0);
      cycle(4'hF, 1'b0, 1'b0);
      chk("drain_abort_resume.gnt", 32'(gnt), 32'b0001);
      check_model("drain_abort_resume");

      // Overflowing return while idle and full
      do_reset();
      cycle(4'h0, 1'b0, 1'b0);
      cycle(4'h0, 1'b1, 1'b0);
      chk("ovf.credit_cnt", 32'(credit_cnt), 32'd64);
      chk("ovf.credit_err", 32'(credit_err), 32'd1);
      for (int i = 0; i < 100; i++) cycle(4'h0, 1'b0, 1'b0);
      chk("ovf_sticky.credit_err", 32'(credit_err), 32'd1);
      check_model("ovf_sticky");

      // Reset mid-stream at 30 credits
      for (int i = 0; i < 34; i++) cycle(4'hF, 1'b0, 1'b0);
      chk("mid.credit_cnt", 32'(credit_cnt), 32'd30);
      do_reset();
      cycle(4'hF, 1'b0, 1'b0);
      chk("post_rst.gnt", 32'(gnt), 32'b0001);
      check_model("post_rst");

      // Randomized traffic against the model
      do_reset();
      d    = 1'b0;
      hold = 0;
      for (int i = 0; i < 3000; i++) begin
         rr = NPORT'($urandom);
         if (hold == 0) begin
            if ($urandom_range(0, 5) == 0) d = ~d;
            hold = $urandom_range(5, 60);
         end else begin
            hold--;
         end
         rt = (m_cnt < MAXCREDIT) && ($urandom_range(0, 2) == 0);
         cycle(rr, rt, d);
         check_model("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
